// File: rtl/sdram_port_arbiter_if.sv
// rtl/sdram_port_arbiter_if.sv - loader, tape and SDRAM port signals of the arbiter
// Ports:
//   ld_active, ld_wr, ld_addr, ld_data, ld_wait : loader write side
//   tp_req, tp_addr, tp_data, tp_valid          : tape read side
//   sd_addr, sd_din, sd_we, sd_rd, sd_dout      : SDRAM controller side
// slave  : arbiter view.
// master : requester/controller view.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 25
);
  logic              ld_active;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [7:0]        ld_data;
  logic              ld_wait;
  logic              tp_req;
  logic [ADDR_W-1:0] tp_addr;
  logic [7:0]        tp_data;
  logic              tp_valid;
  logic [ADDR_W-1:0] sd_addr;
  logic [7:0]        sd_din;
  logic              sd_we;
  logic              sd_rd;
  logic [7:0]        sd_dout;

  modport slave (
    input  ld_active, ld_wr, ld_addr, ld_data, tp_req, tp_addr, sd_dout,
    output ld_wait, tp_data, tp_valid, sd_addr, sd_din, sd_we, sd_rd
  );

  modport master (
    output ld_active, ld_wr, ld_addr, ld_data, tp_req, tp_addr, sd_dout,
    input  ld_wait, tp_data, tp_valid, sd_addr, sd_din, sd_we, sd_rd
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - round-robin sharing of one SDRAM byte port between loader writes and tape reads
// Ports:
//   clk_sys : system clock
//   reset   : synchronous active-high reset
//   bus     : sdram_port_arbiter_if.slave (loader, tape and SDRAM signals)
module sdram_port_arbiter #(
  parameter int ADDR_W        = 25,
  parameter int ACCESS_CYCLES = 8
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  sdram_port_arbiter_if.slave   bus
);

  localparam int CNT_W = $clog2(ACCESS_CYCLES + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ld_full_q, ld_full_d;
  logic [ADDR_W-1:0] ld_abuf_q, ld_abuf_d;
  logic [7:0]        ld_dbuf_q, ld_dbuf_d;
  logic              tp_pend_q, tp_pend_d;
  logic [ADDR_W-1:0] tp_abuf_q, tp_abuf_d;
  logic              last_tape_q, last_tape_d;   // 1: tape was granted last
  logic              is_rd_q, is_rd_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [7:0]        sd_din_q, sd_din_d;
  logic              sd_we_q, sd_we_d;
  logic              sd_rd_q, sd_rd_d;
  logic [7:0]        tp_data_q, tp_data_d;
  logic              tp_valid_q, tp_valid_d;
  logic              pick_tape;

  // Download-active is advisory: accepted writes always complete.
  logic unused_ld_active;
  assign unused_ld_active = bus.ld_active;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ld_full_d   = ld_full_q;
    ld_abuf_d   = ld_abuf_q;
    ld_dbuf_d   = ld_dbuf_q;
    tp_pend_d   = tp_pend_q;
    tp_abuf_d   = tp_abuf_q;
    last_tape_d = last_tape_q;
    is_rd_d     = is_rd_q;
    sd_addr_d   = sd_addr_q;
    sd_din_d    = sd_din_q;
    sd_we_d     = 1'b0;
    sd_rd_d     = 1'b0;
    tp_data_d   = tp_data_q;
    tp_valid_d  = 1'b0;
    pick_tape   = 1'b0;

    // Source buffers empty on the strobe cycle; a same-cycle request refills them.
    if (sd_we_q) ld_full_d = 1'b0;
    if (bus.ld_wr && (!ld_full_q || sd_we_q)) begin
      ld_full_d = 1'b1;
      ld_abuf_d = bus.ld_addr;
      ld_dbuf_d = bus.ld_data;
    end
    if (sd_rd_q) tp_pend_d = 1'b0;
    if (bus.tp_req) begin
      tp_pend_d = 1'b1;
      tp_abuf_d = bus.tp_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (ld_full_q || tp_pend_q) begin
          pick_tape = tp_pend_q && (!ld_full_q || !last_tape_q);
          if (pick_tape) begin
            sd_rd_d     = 1'b1;
            // A tape request in the grant cycle is the latest one and wins.
            sd_addr_d   = bus.tp_req ? bus.tp_addr : tp_abuf_q;
            last_tape_d = 1'b1;
            is_rd_d     = 1'b1;
          end else begin
            sd_we_d     = 1'b1;
            sd_addr_d   = ld_abuf_q;
            sd_din_d    = ld_dbuf_q;
            last_tape_d = 1'b0;
            is_rd_d     = 1'b0;
          end
          cnt_d   = CNT_W'(ACCESS_CYCLES);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (is_rd_q) begin
            tp_data_d  = bus.sd_dout;
            tp_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      ld_full_q   <= 1'b0;
      ld_abuf_q   <= '0;
      ld_dbuf_q   <= '0;
      tp_pend_q   <= 1'b0;
      tp_abuf_q   <= '0;
      last_tape_q <= 1'b1;
      is_rd_q     <= 1'b0;
      sd_addr_q   <= '0;
      sd_din_q    <= '0;
      sd_we_q     <= 1'b0;
      sd_rd_q     <= 1'b0;
      tp_data_q   <= '0;
      tp_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ld_full_q   <= ld_full_d;
      ld_abuf_q   <= ld_abuf_d;
      ld_dbuf_q   <= ld_dbuf_d;
      tp_pend_q   <= tp_pend_d;
      tp_abuf_q   <= tp_abuf_d;
      last_tape_q <= last_tape_d;
      is_rd_q     <= is_rd_d;
      sd_addr_q   <= sd_addr_d;
      sd_din_q    <= sd_din_d;
      sd_we_q     <= sd_we_d;
      sd_rd_q     <= sd_rd_d;
      tp_data_q   <= tp_data_d;
      tp_valid_q  <= tp_valid_d;
    end
  end

  assign bus.ld_wait  = ld_full_q;
  assign bus.tp_data  = tp_data_q;
  assign bus.tp_valid = tp_valid_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_din   = sd_din_q;
  assign bus.sd_we    = sd_we_q;
  assign bus.sd_rd    = sd_rd_q;

endmodule
